issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// Issue controller: buffers fetched instructions in a small FIFO and issues
// them in order to the Decoder, allocating a ROB slot per issued instruction.
// Loads/stores are routed to the LSB, everything else to the RS. A rollback
// flushes the queue and reloads the ROB tail, with one FLUSH cycle after it.
module issue_ctrl #(
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [3:0]  rb_rob_pos,
   input  logic        if_valid,
   input  logic [31:0] if_inst,
   input  logic [31:0] if_pc,
   input  logic        if_pre_j,
   output logic        if_ready,
   input  logic        rob_full,
   input  logic        rs_full,
   input  logic        lsb_full,
   output logic        dec_valid,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc,
   output logic        dec_pre_j,
   output logic [3:0]  dec_rob_pos,
   output logic        dec_to_lsb,
   output logic [15:0] stall_cnt
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(QDEPTH);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

   state_e        state_q;
   logic [31:0]   inst_mem_q [QDEPTH];
   logic [31:0]   pc_mem_q   [QDEPTH];
   logic          prej_mem_q [QDEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [3:0]    rob_tail_q;
   logic          dec_valid_q, dec_pre_j_q, dec_to_lsb_q;
   logic [31:0]   dec_inst_q, dec_pc_q;
   logic [3:0]    dec_rob_pos_q;
   logic [15:0]   stall_q;

   logic [31:0]   head_inst;
   logic          head_to_lsb, unit_full, run, push, pop, stall;

   assign head_inst   = inst_mem_q[head_q];
   assign head_to_lsb = (head_inst[6:0] == 7'b0000011) || (head_inst[6:0] == 7'b0100011);
   assign unit_full   = head_to_lsb ? lsb_full : rs_full;
   assign run         = (state_q == RUN);

   assign if_ready = (cnt_q < CNT_FULL) && run && !rollback;
   assign push     = if_valid && if_ready && rdy;
   // Only the head may issue; a blocked head stalls everything behind it.
   assign pop      = (cnt_q != '0) && rdy && !rollback && run && !rob_full && !unit_full;
   assign stall    = rdy && run && (cnt_q != '0) && !rollback && !pop;

   // Next pointer/count; rollback wipes the queue and drops any push.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (rdy && rollback) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Queue storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[tail_q] <= if_inst;
         pc_mem_q[tail_q]   <= if_pc;
         prej_mem_q[tail_q] <= if_pre_j;
      end
   end

   // Control FSM, ROB tail allocation, registered issue outputs, stall counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         head_q        <= '0;
         tail_q        <= '0;
         cnt_q         <= '0;
         rob_tail_q    <= '0;
         dec_valid_q   <= 1'b0;
         dec_inst_q    <= '0;
         dec_pc_q      <= '0;
         dec_pre_j_q   <= 1'b0;
         dec_rob_pos_q <= '0;
         dec_to_lsb_q  <= 1'b0;
         stall_q       <= '0;
      end else if (rdy) begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         case (state_q)
            RUN:     if (rollback) state_q <= FLUSH;
            default: state_q <= RUN;
         endcase
         if (rollback)  rob_tail_q <= rb_rob_pos;
         else if (pop)  rob_tail_q <= rob_tail_q + 4'd1;
         dec_valid_q <= pop;
         if (pop) begin
            dec_inst_q    <= head_inst;
            dec_pc_q      <= pc_mem_q[head_q];
            dec_pre_j_q   <= prej_mem_q[head_q];
            dec_rob_pos_q <= rob_tail_q;
            dec_to_lsb_q  <= head_to_lsb;
         end
         if (stall && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      end
   end

   assign dec_valid   = dec_valid_q;
   assign dec_inst    = dec_inst_q;
   assign dec_pc      = dec_pc_q;
   assign dec_pre_j   = dec_pre_j_q;
   assign dec_rob_pos = dec_rob_pos_q;
   assign dec_to_lsb  = dec_to_lsb_q;
   assign stall_cnt   = stall_q;

endmodule
